// File: rtl/i2c_reg_seq_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
package i2c_reg_seq_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_WR      = 3'd1,
    CMD_RD      = 3'd2,
    CMD_STOP    = 3'd3,
    CMD_RESTART = 3'd4
  } i2c_cmd_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_DEV_W   = 4'd2,
    S_REG     = 4'd3,
    S_WDATA   = 4'd4,
    S_RESTART = 4'd5,
    S_DEV_R   = 4'd6,
    S_RDATA   = 4'd7,
    S_STOP    = 4'd8,
    S_RESP    = 4'd9
  } seq_state_e;

  localparam logic [7:0]  I2C_RD_LAST_NACK = 8'h01;
  localparam logic [15:0] TIMEOUT_CYCLES   = 16'd65535;

  function automatic i2c_cmd_e state_cmd(input seq_state_e s);
    case (s)
      S_START:   return CMD_START;
      S_RESTART: return CMD_RESTART;
      S_STOP:    return CMD_STOP;
      S_RDATA:   return CMD_RD;
      default:   return CMD_WR;
    endcase
  endfunction

  function automatic logic is_byte_state(input seq_state_e s);
    case (s)
      S_DEV_W, S_REG, S_WDATA, S_DEV_R, S_RDATA: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // Successor of a state once its command completed without error.
  function automatic seq_state_e next_state(input seq_state_e s, input logic rnw);
    case (s)
      S_START:   return S_DEV_W;
      S_DEV_W:   return S_REG;
      S_REG:     return rnw ? S_RESTART : S_WDATA;
      S_WDATA:   return S_STOP;
      S_RESTART: return S_DEV_R;
      S_DEV_R:   return S_RDATA;
      S_RDATA:   return S_STOP;
      S_STOP:    return S_RESP;
      default:   return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_reg_seq.sv
// Turns one register read/write request into an I2C master command sequence.
// Optional per-command watchdog enabled by defining I2C_REG_SEQ_TIMEOUT_EN.
module i2c_reg_seq
  import i2c_reg_seq_pkg::*;
#(
  parameter logic [15:0] DVSR = 16'd250
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rnw_i,
  input  logic [6:0]  req_dev_addr_i,
  input  logic [7:0]  req_reg_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [2:0]  cmd_o,
  output logic [7:0]  din_o,
  output logic [15:0] dvsr_o,
  output logic        wr_i2c_o,
  input  logic        ready_i,
  input  logic        done_tick_i,
  input  logic        ack_i,
  input  logic [7:0]  dout_i
);

  seq_state_e state_r, state_s;
  logic       wait_r, wait_s;   // 0: ISSUE phase, 1: WAIT phase
  logic       skip_r, skip_s;
  logic       rnw_r, rnw_s;
  logic [6:0] dev_r, dev_s;
  logic [7:0] reg_addr_r, reg_addr_s, wdata_r, wdata_s;
  logic       ready_r, rsp_valid_r, rsp_valid_s, err_r, err_s, wr_r, wr_s;
  logic [7:0] rdata_r, rdata_s, din_r, din_s, issue_din_s;
  logic [2:0] cmd_r, cmd_s;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt_r, to_cnt_s;
`endif

  assign req_ready_o = ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rdata_r;
  assign rsp_err_o   = err_r;
  assign cmd_o       = cmd_r;
  assign din_o       = din_r;
  assign wr_i2c_o    = wr_r;
  assign dvsr_o      = DVSR;

  // Byte presented on din_o when the current state issues its command.
  always_comb begin
    issue_din_s = 8'h00;
    case (state_r)
      S_DEV_W: issue_din_s = {dev_r, 1'b0};
      S_REG:   issue_din_s = reg_addr_r;
      S_WDATA: issue_din_s = wdata_r;
      S_DEV_R: issue_din_s = {dev_r, 1'b1};
      S_RDATA: issue_din_s = I2C_RD_LAST_NACK;
      default: issue_din_s = 8'h00;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    wait_s      = wait_r;
    skip_s      = 1'b0;
    rnw_s       = rnw_r;
    dev_s       = dev_r;
    reg_addr_s  = reg_addr_r;
    wdata_s     = wdata_r;
    rsp_valid_s = 1'b0;
    err_s       = err_r;
    wr_s        = 1'b0;
    rdata_s     = rdata_r;
    din_s       = din_r;
    cmd_s       = cmd_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid_i) begin
          rnw_s      = req_rnw_i;
          dev_s      = req_dev_addr_i;
          reg_addr_s = req_reg_addr_i;
          wdata_s    = req_wdata_i;
          err_s      = 1'b0;
          state_s    = S_START;
          wait_s     = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RESP: state_s = S_IDLE;
      default: begin
        if (!wait_r) begin
          if (ready_i) begin
            wr_s   = 1'b1;
            cmd_s  = state_cmd(state_r);
            din_s  = issue_din_s;
            wait_s = 1'b1;
            skip_s = 1'b1;
          end else begin
            wait_s = 1'b0;
          end
        end else if (is_byte_state(state_r)) begin
          if (done_tick_i) begin
            wait_s = 1'b0;
            if (state_r == S_RDATA) begin
              rdata_s = dout_i;
              state_s = S_STOP;
            end else if (ack_i) begin
              err_s   = 1'b1;
              state_s = S_STOP;
            end else begin
              state_s = next_state(state_r, rnw_r);
            end
          end else begin
            wait_s = 1'b1;
          end
        end else if (!skip_r && ready_i) begin
          // The master drops ready only after seeing the strobe, so the first WAIT cycle is skipped.
          wait_s      = 1'b0;
          state_s     = next_state(state_r, rnw_r);
          rsp_valid_s = (state_r == S_STOP);
        end else begin
          wait_s = 1'b1;
        end
      end
    endcase
`ifdef I2C_REG_SEQ_TIMEOUT_EN
    to_cnt_s = 16'd0;
    if (state_r != S_IDLE && state_r != S_RESP) begin
      if (to_cnt_r == TIMEOUT_CYCLES) begin
        err_s  = 1'b1;
        wr_s   = 1'b0;
        cmd_s  = cmd_r;
        din_s  = din_r;
        wait_s = 1'b0;
        skip_s = 1'b0;
        if (state_r == S_STOP) begin
          state_s     = S_RESP;
          rsp_valid_s = 1'b1;
        end else begin
          state_s     = S_STOP;
          rsp_valid_s = 1'b0;
        end
      end else if (state_s != state_r || wait_s != wait_r) begin
        to_cnt_s = 16'd0;
      end else begin
        to_cnt_s = to_cnt_r + 16'd1;
      end
    end else begin
      to_cnt_s = 16'd0;
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= S_IDLE;
      wait_r      <= 1'b0;
      skip_r      <= 1'b0;
      rnw_r       <= 1'b0;
      dev_r       <= 7'd0;
      reg_addr_r  <= 8'd0;
      wdata_r     <= 8'd0;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      wr_r        <= 1'b0;
      rdata_r     <= 8'd0;
      din_r       <= 8'd0;
      cmd_r       <= 3'd0;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
      to_cnt_r    <= 16'd0;
`endif
    end else begin
      state_r     <= state_s;
      wait_r      <= wait_s;
      skip_r      <= skip_s;
      rnw_r       <= rnw_s;
      dev_r       <= dev_s;
      reg_addr_r  <= reg_addr_s;
      wdata_r     <= wdata_s;
      ready_r     <= (state_s == S_IDLE);
      rsp_valid_r <= rsp_valid_s;
      err_r       <= err_s;
      wr_r        <= wr_s;
      rdata_r     <= rdata_s;
      din_r       <= din_s;
      cmd_r       <= cmd_s;
`ifdef I2C_REG_SEQ_TIMEOUT_EN
      to_cnt_r    <= to_cnt_s;
`endif
    end
  end

endmodule
